// File: rtl/wb_msg_sink_pkg.sv
// ============================================================================
// Module      : wb_msg_sink_pkg
// Description : Register map and bit positions shared by the message sink.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_msg_sink_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_STATS  = 2'd3;

    localparam int ST_FULL    = 31;
    localparam int ST_EMPTY   = 30;

    localparam int CTRL_FLUSH = 0;
    localparam int CTRL_IRQEN = 1;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/msg_fifo_sync.sv
// ============================================================================
// Module      : msg_fifo_sync
// Description : Single-clock first-word-fall-through FIFO with synchronous flush.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module msg_fifo_sync #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [WIDTH-1:0] o_data,
    output logic [CW-1:0]    o_count,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    // Flush wins over any pop or push presented on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push && !w_pop)      r_count <= r_count + CW'(1);
            else if (w_pop && !w_push) r_count <= r_count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

`default_nettype wire

// File: rtl/wb_msg_sink.sv
// ============================================================================
// Module      : wb_msg_sink
// Description : Wishbone B3 slave buffering message words into a FWFT stream,
//               with STATUS/CTRL registers and a level interrupt.
//               Optional drop counter at address 3: WB_MSG_SINK_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_msg_sink
    import wb_msg_sink_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst_sys_n,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        irq
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic          r_ack;
    logic          r_err;
    logic [31:0]   r_dat;
    logic          r_irq_en;

    logic [CW-1:0] w_count;
    logic          w_full;
    logic          w_empty;
    logic          w_req;
    logic [1:0]    w_reg;
    logic          w_push;
    logic          w_flush;
    logic          w_ctrl_wr;
    logic          w_ack_nxt;
    logic          w_err_nxt;
    logic [31:0]   w_dat_nxt;
    logic [31:0]   w_status;
    logic          w_unused_adr;

`ifdef WB_MSG_SINK_STATS_EN
    logic [15:0]   r_drops;
    logic          w_drop;
    logic          w_stats_clr;
`endif

    assign w_unused_adr = ^{wb_adr_i[31:4], wb_adr_i[1:0]};
    assign w_reg        = wb_adr_i[3:2];
    // A fresh request only when the previous cycle did not terminate one.
    assign w_req        = wb_cyc_i & wb_stb_i & ~r_ack & ~r_err;

    always_comb begin
        w_ack_nxt = 1'b0;
        w_err_nxt = 1'b0;
        w_dat_nxt = '0;
        w_push    = 1'b0;
        w_flush   = 1'b0;
        w_ctrl_wr = 1'b0;
`ifdef WB_MSG_SINK_STATS_EN
        w_drop      = 1'b0;
        w_stats_clr = 1'b0;
`endif
        w_status           = '0;
        w_status[ST_FULL]  = w_full;
        w_status[ST_EMPTY] = w_empty;
        w_status[CW-1:0]   = w_count;

        if (w_req) begin
            case (w_reg)
                REG_DATA: begin
                    if (!wb_we_i) begin
                        w_ack_nxt = 1'b1;
                    end else if (wb_sel_i == 4'hF && !w_full) begin
                        w_push    = 1'b1;
                        w_ack_nxt = 1'b1;
                    end else begin
                        w_err_nxt = 1'b1;
`ifdef WB_MSG_SINK_STATS_EN
                        w_drop    = 1'b1;
`endif
                    end
                end
                REG_STATUS: begin
                    w_ack_nxt = 1'b1;
                    if (!wb_we_i) w_dat_nxt = w_status;
                end
                REG_CTRL: begin
                    w_ack_nxt = 1'b1;
                    if (wb_we_i) begin
                        if (wb_sel_i[0]) begin
                            w_ctrl_wr = 1'b1;
                            w_flush   = wb_dat_i[CTRL_FLUSH];
                        end
                    end else begin
                        w_dat_nxt[CTRL_IRQEN] = r_irq_en;
                    end
                end
                default: begin
                    w_ack_nxt = 1'b1;
`ifdef WB_MSG_SINK_STATS_EN
                    if (wb_we_i) w_stats_clr = 1'b1;
                    else         w_dat_nxt   = {16'h0, r_drops};
`endif
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            r_ack    <= 1'b0;
            r_err    <= 1'b0;
            r_dat    <= '0;
            r_irq_en <= 1'b0;
        end else begin
            r_ack <= w_ack_nxt;
            r_err <= w_err_nxt;
            r_dat <= w_dat_nxt;
            if (w_ctrl_wr) r_irq_en <= wb_dat_i[CTRL_IRQEN];
        end
    end

`ifdef WB_MSG_SINK_STATS_EN
    always_ff @(posedge clk or negedge rst_sys_n) begin
        if (!rst_sys_n)       r_drops <= '0;
        else if (w_stats_clr) r_drops <= '0;
        else if (w_drop)      r_drops <= sat_inc16(r_drops);
    end
`endif

    msg_fifo_sync #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_sys_n),
        .i_push  (w_push),
        .i_data  (wb_dat_i),
        .i_pop   (out_ready),
        .i_flush (w_flush),
        .o_data  (out_data),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign wb_ack_o  = r_ack;
    assign wb_err_o  = r_err;
    assign wb_dat_o  = r_dat;
    assign out_valid = ~w_empty;
    assign irq       = r_irq_en & ~w_empty;

endmodule

`default_nettype wire

// File: tb/tb_wb_msg_sink.sv
// ============================================================================
// Module      : tb_wb_msg_sink
// Description : Self-checking bench for wb_msg_sink with a stream scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_msg_sink;
    import wb_msg_sink_pkg::*;

`ifdef WB_MSG_SINK_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_sys_n = 1'b0;
    logic [31:0] wb_adr_i = '0;
    logic [31:0] wb_dat_i = '0;
    logic [3:0]  wb_sel_i = '0;
    logic        wb_we_i = 1'b0;
    logic        wb_cyc_i = 1'b0;
    logic        wb_stb_i = 1'b0;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        irq;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] q[$];
    logic        exp_irq_en = 1'b0;

    always #5 clk = ~clk;

    wb_msg_sink #(.DEPTH(16)) dut (
        .clk       (clk),
        .rst_sys_n (rst_sys_n),
        .wb_adr_i  (wb_adr_i),
        .wb_dat_i  (wb_dat_i),
        .wb_sel_i  (wb_sel_i),
        .wb_we_i   (wb_we_i),
        .wb_cyc_i  (wb_cyc_i),
        .wb_stb_i  (wb_stb_i),
        .wb_dat_o  (wb_dat_o),
        .wb_ack_o  (wb_ack_o),
        .wb_err_o  (wb_err_o),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .irq       (irq)
    );

    // One Wishbone access; returns the termination seen in the first cycle after the request edge.
    task automatic wb_xfer(input logic we, input logic [1:0] ri, input logic [31:0] wd,
                           input logic [3:0] sel, input logic rdy,
                           output logic ack, output logic err, output logic [31:0] rd);
        int n;
        @(posedge clk); #1;
        wb_adr_i = {28'h0001230, ri, 2'b00};
        wb_dat_i = wd;
        wb_sel_i = sel;
        wb_we_i  = we;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        out_ready = rdy;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n = 0;
        while (!wb_ack_o && !wb_err_o && n < 4) begin
            @(posedge clk); #1;
            n++;
        end
        ack = wb_ack_o;
        err = wb_err_o;
        rd  = wb_dat_o;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        tests++;
        if (n != 0 || (ack && err)) begin
            fails++;
            $display("FAIL wb_term: extra_latency=%0d ack=%b err=%b, required latency 1 with exactly one of ack/err", n, ack, err);
        end
    endtask

    task automatic wr_data(input logic [31:0] d, input logic rdy, output logic ack, output logic err);
        logic [31:0] rd;
        wb_xfer(1'b1, REG_DATA, d, 4'hF, rdy, ack, err, rd);
        if (ack) q.push_back(d);
    endtask

    task automatic rd_reg(input logic [1:0] ri, output logic [31:0] v);
        logic a, e;
        logic [31:0] rd;
        wb_xfer(1'b0, ri, 32'h0, 4'hF, 1'b0, a, e, rd);
        v = a ? rd : 32'hxxxx_xxxx;
    endtask

    task automatic pop_n(input int n);
        @(posedge clk); #1;
        out_ready = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        logic [31:0] v;
        #12;
        tests++;
        if (wb_ack_o !== 1'b0 || wb_err_o !== 1'b0 || wb_dat_o !== 32'h0 || out_valid !== 1'b0 || irq !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: ack=%b err=%b dat=%h valid=%b irq=%b, required all 0", wb_ack_o, wb_err_o, wb_dat_o, out_valid, irq);
        end
        @(posedge clk); #1;
        rst_sys_n = 1'b1;
        rd_reg(REG_STATUS, v);
        tests++;
        if (v !== 32'h4000_0000) begin
            fails++;
            $display("FAIL reset_status: got %h required 40000000", v);
        end
        @(posedge clk); #1;
        tests++;
        if (wb_dat_o !== 32'h0 || wb_ack_o !== 1'b0) begin
            fails++;
            $display("FAIL idle_bus: dat=%h ack=%b, required 0/0", wb_dat_o, wb_ack_o);
        end
    endtask

    task automatic test_basic;
        logic a, e;
        logic [31:0] v;
        wb_xfer(1'b1, REG_CTRL, 32'h2, 4'hF, 1'b0, a, e, v);
        exp_irq_en = 1'b1;
        tests++;
        if (a !== 1'b1) begin fails++; $display("FAIL ctrl_wr_ack: got %b required 1", a); end
        for (int i = 1; i <= 2; i++) begin
            wr_data(32'hA5A5_0000 + 32'(i), 1'b0, a, e);
            tests++;
            if (a !== 1'b1) begin fails++; $display("FAIL data_wr_ack: word %0d ack=%b required 1", i, a); end
        end
        rd_reg(REG_STATUS, v);
        tests++;
        if (v !== 32'h0000_0002) begin fails++; $display("FAIL status_two: got %h required 00000002", v); end
        tests++;
        if (out_valid !== 1'b1 || out_data !== 32'hA5A5_0001 || irq !== 1'b1) begin
            fails++;
            $display("FAIL head_hold: valid=%b data=%h irq=%b, required 1/a5a50001/1", out_valid, out_data, irq);
        end
        pop_n(2);
        tests++;
        if (out_valid !== 1'b0 || irq !== 1'b0 || q.size() != 0) begin
            fails++;
            $display("FAIL drain: valid=%b irq=%b model_left=%0d, required 0/0/0", out_valid, irq, q.size());
        end
        rd_reg(REG_CTRL, v);
        tests++;
        if (v !== 32'h0000_0002) begin fails++; $display("FAIL ctrl_read: got %h required 00000002", v); end
    endtask

    task automatic test_full;
        logic a, e;
        logic [31:0] v;
        for (int i = 0; i < 16; i++) begin
            wr_data(32'hF000_0000 + 32'(i), 1'b0, a, e);
            tests++;
            if (a !== 1'b1) begin fails++; $display("FAIL fill_ack: word %0d ack=%b required 1", i, a); end
        end
        wr_data(32'hDEAD_0017, 1'b0, a, e);
        tests++;
        if (e !== 1'b1 || a !== 1'b0) begin fails++; $display("FAIL overflow_err: ack=%b err=%b required 0/1", a, e); end
        rd_reg(REG_STATUS, v);
        tests++;
        if (v !== 32'h8000_0010) begin fails++; $display("FAIL status_full: got %h required 80000010", v); end
        rd_reg(REG_STATS, v);
        tests++;
        if (v !== (STATS ? 32'h1 : 32'h0)) begin fails++; $display("FAIL stats_one: got %h required %h", v, STATS ? 32'h1 : 32'h0); end
    endtask

    task automatic test_full_pop;
        logic a, e;
        logic [31:0] v;
        wr_data(32'hDEAD_0018, 1'b1, a, e);
        tests++;
        if (e !== 1'b1 || a !== 1'b0) begin fails++; $display("FAIL full_pop_err: ack=%b err=%b required 0/1", a, e); end
        rd_reg(REG_STATUS, v);
        tests++;
        if (v !== 32'h0000_000F) begin fails++; $display("FAIL status_15: got %h required 0000000f", v); end
        rd_reg(REG_STATS, v);
        tests++;
        if (v !== (STATS ? 32'h2 : 32'h0)) begin fails++; $display("FAIL stats_two: got %h required %h", v, STATS ? 32'h2 : 32'h0); end
        wb_xfer(1'b1, REG_STATS, 32'h0, 4'h1, 1'b0, a, e, v);
        rd_reg(REG_STATS, v);
        tests++;
        if (a !== 1'b1 || v !== 32'h0) begin fails++; $display("FAIL stats_clear: ack=%b val=%h required 1/00000000", a, v); end
        pop_n(10);
        rd_reg(REG_STATUS, v);
        tests++;
        if (v !== 32'h0000_0005) begin fails++; $display("FAIL status_5: got %h required 00000005", v); end
        for (int i = 0; i < 12; i++) begin
            wr_data(32'hC000_0000 + 32'(i), 1'b1, a, e);
            tests++;
            if (a !== 1'b1) begin fails++; $display("FAIL push_pop_ack: iter %0d ack=%b required 1", i, a); end
        end
        rd_reg(REG_STATUS, v);
        tests++;
        if (v !== 32'h0000_0005) begin fails++; $display("FAIL push_pop_count: got %h required 00000005", v); end
    endtask

    task automatic test_sel_flush;
        logic a, e;
        logic [31:0] v, rd;
        wb_xfer(1'b1, REG_DATA, 32'hBAD0_0003, 4'h3, 1'b0, a, e, rd);
        tests++;
        if (e !== 1'b1 || a !== 1'b0) begin fails++; $display("FAIL subword_err: ack=%b err=%b required 0/1", a, e); end
        rd_reg(REG_STATS, v);
        tests++;
        if (v !== (STATS ? 32'h1 : 32'h0)) begin fails++; $display("FAIL stats_sel: got %h required %h", v, STATS ? 32'h1 : 32'h0); end
        wr_data(32'h7000_0001, 1'b0, a, e);
        wr_data(32'h7000_0002, 1'b0, a, e);
        rd_reg(REG_STATUS, v);
        tests++;
        if (v !== 32'h0000_0007) begin fails++; $display("FAIL status_7: got %h required 00000007", v); end
        wb_xfer(1'b1, REG_CTRL, 32'h1, 4'hF, 1'b1, a, e, rd);
        tests++;
        if (a !== 1'b1 || out_valid !== 1'b0 || irq !== 1'b0) begin
            fails++;
            $display("FAIL flush_cycle: ack=%b valid=%b irq=%b, required 1/0/0", a, out_valid, irq);
        end
        q.delete();
        exp_irq_en = 1'b0;
        rd_reg(REG_STATUS, v);
        tests++;
        if (v !== 32'h4000_0000) begin fails++; $display("FAIL status_flushed: got %h required 40000000", v); end
        wb_xfer(1'b1, REG_CTRL, 32'h2, 4'h2, 1'b0, a, e, rd);
        rd_reg(REG_CTRL, v);
        tests++;
        if (a !== 1'b1 || v !== 32'h0) begin fails++; $display("FAIL ctrl_subword: ack=%b ctrl=%h required 1/00000000", a, v); end
        wb_xfer(1'b1, REG_STATUS, 32'hFFFF_FFFF, 4'hF, 1'b0, a, e, rd);
        rd_reg(REG_STATUS, v);
        tests++;
        if (a !== 1'b1 || v !== 32'h4000_0000) begin fails++; $display("FAIL status_wr_ignored: ack=%b status=%h required 1/40000000", a, v); end
    endtask

    task automatic test_reset_midtx;
        logic a, e;
        logic [31:0] v;
        wr_data(32'h1111_0001, 1'b0, a, e);
        @(posedge clk); #1;
        wb_adr_i = {28'h0, REG_DATA, 2'b00};
        wb_dat_i = 32'h1111_0002;
        wb_sel_i = 4'hF;
        wb_we_i  = 1'b1;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        rst_sys_n = 1'b0;
        q.delete();
        exp_irq_en = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (wb_ack_o !== 1'b0 || wb_err_o !== 1'b0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_midtx: ack=%b err=%b valid=%b, required 0/0/0", wb_ack_o, wb_err_o, out_valid);
        end
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        rst_sys_n = 1'b1;
        wr_data(32'h1111_0002, 1'b0, a, e);
        tests++;
        if (a !== 1'b1) begin fails++; $display("FAIL retry_ack: got %b required 1", a); end
        rd_reg(REG_STATUS, v);
        tests++;
        if (v !== 32'h0000_0001) begin fails++; $display("FAIL retry_count: got %h required 00000001", v); end
        pop_n(1);
    endtask

    initial begin
        // Stream-side scoreboard consumer, sampled on the falling edge.
        fork
            forever begin
                @(negedge clk);
                if (rst_sys_n) begin
                    tests++;
                    if (out_valid !== (q.size() != 0) || irq !== (exp_irq_en && q.size() != 0)) begin
                        fails++;
                        $display("FAIL stream_flags: valid=%b irq=%b, required valid=%b irq=%b",
                                 out_valid, irq, q.size() != 0, exp_irq_en && q.size() != 0);
                    end
                    if (out_valid && q.size() != 0) begin
                        tests++;
                        if (out_data !== q[0]) begin
                            fails++;
                            $display("FAIL stream_data: got %h required %h", out_data, q[0]);
                        end
                        if (out_ready) void'(q.pop_front());
                    end
                end
            end
            begin
                #500000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "watchdog");
            end
        join_none
        test_reset();
        test_basic();
        test_full();
        test_full_pop();
        test_sel_flush();
        test_reset_midtx();
        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
